// File: rtl/mux_scan_sampler.sv
// Scans N input channels through a select mux: each channel is settled, then
// sampled VOTES times and resolved by majority into one bit of the response.
module mux_scan_sampler #(
  parameter int N      = 16,
  parameter int SEL_W  = $clog2(N),
  parameter int SETTLE = 2,
  parameter int VOTES  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N-1:0]     resp,
  output logic             resp_valid,
  input  logic             resp_ready
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] VOTES_LAST  = CNT_W'(VOTES - 1);
  localparam logic [CNT_W-1:0] HALF        = CNT_W'(VOTES / 2);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] vote_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] ones_sum;
  logic             settle_last;
  logic             vote_last;

  assign ones_sum    = ones_cnt + CNT_W'(in[sel]);
  assign settle_last = (settle_cnt == SETTLE_LAST);
  assign vote_last   = (vote_cnt == VOTES_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Output handshake: resp_valid rises on entry to DONE and stays high with
  // resp frozen until an edge sees resp_ready=1; that edge returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_next = ST_SAMPLE;
      ST_SAMPLE: if (vote_last) state_next = (sel == SEL_LAST) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (resp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel        <= '0;
      resp       <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      settle_cnt <= '0;
      vote_cnt   <= '0;
      ones_cnt   <= '0;
    end else begin
      busy       <= (state_next != ST_IDLE);
      resp_valid <= (state_next == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel        <= '0;
            resp       <= '0;
            settle_cnt <= '0;
            vote_cnt   <= '0;
            ones_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_last ? '0 : settle_cnt + CNT_W'(1);
        end
        ST_SAMPLE: begin
          if (vote_last) begin
            // Majority decision includes the sample taken on this edge.
            resp[sel]  <= (ones_sum > HALF);
            vote_cnt   <= '0;
            ones_cnt   <= '0;
            settle_cnt <= '0;
            if (sel != SEL_LAST) sel <= sel + SEL_W'(1);
          end else begin
            vote_cnt <= vote_cnt + CNT_W'(1);
            ones_cnt <= ones_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: per-edge stimulus tables resolved by a
// sample-window majority model, plus handshake and reset scenarios.
module tb_mux_scan_sampler;
  localparam int N      = 16;
  localparam int SEL_W  = 4;
  localparam int SETTLE = 2;
  localparam int VOTES  = 3;
  localparam int PER    = SETTLE + VOTES;
  localparam int LAT    = N * PER;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in;
  logic             start;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [N-1:0]     resp;
  logic             resp_valid;
  logic             resp_ready;

  int vectors = 0;
  int errors  = 0;
  // stim[k] is the value of in presented at the k-th edge after the accepting edge.
  logic [N-1:0] stim [0:LAT];
  logic [N-1:0] last_resp;

  always #5 clk = ~clk;

  mux_scan_sampler #(.N(N), .SEL_W(SEL_W), .SETTLE(SETTLE), .VOTES(VOTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .start      (start),
    .sel        (sel),
    .busy       (busy),
    .resp       (resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready)
  );

  // Channel c is observed on edges c*PER+SETTLE+1 .. c*PER+SETTLE+VOTES.
  function automatic logic [N-1:0] model_resp();
    logic [N-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) begin
      int ones;
      ones = 0;
      for (int j = 1; j <= VOTES; j++) ones += int'(stim[c*PER + SETTLE + j][c]);
      r[c] = (ones > VOTES / 2);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int k = 0; k <= LAT; k++) stim[k] = N'($urandom);
  endtask

  task automatic fill_const(input logic [N-1:0] v);
    for (int k = 0; k <= LAT; k++) stim[k] = v;
  endtask

  task automatic run_scan(input int abort_at, input bit noise, input string tag);
    logic [N-1:0] exp_resp;
    int exp_sel;
    exp_resp = model_resp();
    in = stim[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (sel !== '0 || busy !== 1'b1 || resp_valid !== 1'b0 || resp !== '0) begin
      errors++;
      $display("FAIL %s_accept: sel=%0d busy=%b rv=%b resp=%h, required sel=0 busy=1 rv=0 resp=0",
               tag, sel, busy, resp_valid, resp);
    end
    for (int k = 1; k <= LAT; k++) begin
      if (k == abort_at) return;
      in = stim[k];
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      exp_sel = (k / PER > N - 1) ? N - 1 : k / PER;
      vectors++;
      if (sel !== SEL_W'(exp_sel) || busy !== 1'b1 || resp_valid !== (k == LAT)) begin
        errors++;
        $display("FAIL %s_edge%0d: sel=%0d busy=%b rv=%b, required sel=%0d busy=1 rv=%b",
                 tag, k, sel, busy, resp_valid, exp_sel, (k == LAT));
      end
    end
    start = 1'b0;
    vectors++;
    if (resp !== exp_resp) begin
      errors++;
      $display("FAIL %s_resp: resp=%h, required %h", tag, resp, exp_resp);
    end
    last_resp = exp_resp;
  endtask

  task automatic ack(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || resp !== last_resp) begin
        errors++;
        $display("FAIL %s_ack%0d: busy=%b rv=%b resp=%h, required busy=0 rv=0 resp=%h",
                 tag, i, busy, resp_valid, resp, last_resp);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    resp_ready = 1'b0;
    in = N'($urandom);
    repeat (3) tick();
    vectors++;
    if (sel !== '0 || resp !== '0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sel=%0d resp=%h busy=%b rv=%b, required all 0",
               sel, resp, busy, resp_valid);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b1 || sel !== '0) begin
      errors++;
      $display("FAIL reset_first_start: busy=%b sel=%0d, required busy=1 sel=0", busy, sel);
    end
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_static();
    fill_const(16'hA5C3);
    run_scan(0, 1'b0, "static");
    vectors++;
    if (resp !== 16'hA5C3 || sel !== 4'd15) begin
      errors++;
      $display("FAIL static_const: resp=%h sel=%0d, required a5c3 sel=15", resp, sel);
    end
    ack("static");
  endtask

  task automatic test_votes();
    fill_const('0);
    stim[5*PER + SETTLE + 1][5] = 1'b1;
    stim[5*PER + SETTLE + 3][5] = 1'b1;
    run_scan(0, 1'b0, "vote2of3");
    vectors++;
    if (resp !== 16'h0020) begin
      errors++;
      $display("FAIL vote2of3_const: resp=%h, required 0020", resp);
    end
    ack("vote2of3");
    fill_const('0);
    stim[5*PER + SETTLE + 2][5] = 1'b1;
    run_scan(0, 1'b0, "vote1of3");
    vectors++;
    if (resp !== 16'h0000) begin
      errors++;
      $display("FAIL vote1of3_const: resp=%h, required 0000", resp);
    end
    ack("vote1of3");
  endtask

  task automatic test_settle_glitch();
    fill_const('0);
    for (int j = 1; j <= SETTLE; j++) stim[3*PER + j][3] = j[0];
    stim[3*PER + 1][3] = 1'b1;
    run_scan(0, 1'b0, "settle");
    vectors++;
    if (resp[3] !== 1'b0) begin
      errors++;
      $display("FAIL settle_bit3: resp[3]=%b, required 0", resp[3]);
    end
    ack("settle");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_scan(0, 1'b1, "random");
      ack("random");
    end
  endtask

  task automatic test_handshake();
    fill_random();
    run_scan(0, 1'b0, "hold");
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (resp_valid !== 1'b1 || resp !== last_resp || busy !== 1'b1 || sel !== 4'd15) begin
        errors++;
        $display("FAIL hold_%0d: rv=%b resp=%h busy=%b sel=%0d, required rv=1 resp=%h busy=1 sel=15",
                 i, resp_valid, resp, busy, sel, last_resp);
      end
    end
    resp_ready = 1'b1;
    start = 1'b1;
    tick();
    resp_ready = 1'b0;
    start = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || resp !== last_resp) begin
      errors++;
      $display("FAIL exit_start_ignored: busy=%b rv=%b resp=%h, required busy=0 rv=0 resp=%h",
               busy, resp_valid, resp, last_resp);
    end
    fill_random();
    run_scan(0, 1'b0, "restart");
    ack("restart");
  endtask

  task automatic test_mid_reset();
    fill_random();
    run_scan(7*PER + 1, 1'b0, "abort");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (sel !== '0 || resp !== '0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sel=%0d resp=%h busy=%b rv=%b, required all 0",
               sel, resp, busy, resp_valid);
    end
    fill_random();
    run_scan(0, 1'b1, "after_reset");
    ack("after_reset");
  endtask

  initial begin
    test_reset();
    test_static();
    test_votes();
    test_settle_glitch();
    test_random();
    test_handshake();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
